// File: rtl/score4_game_ctrl_if.sv
// Button pulses in, board state and game status out, for the Connect-Four engine.
interface score4_game_ctrl_if #(
  parameter int unsigned ROWS = 6,
  parameter int unsigned COLS = 7
);
  logic                             btn_left;
  logic                             btn_right;
  logic                             btn_drop;
  logic                             btn_restart;
  logic [ROWS-1:0][COLS-1:0][1:0]   panel;
  logic [COLS-1:0]                  play;
  logic                             player;
  logic                             win_a;
  logic                             win_b;
  logic                             draw;
  logic                             busy;
  logic                             err_full;

  modport master (
    output btn_left, btn_right, btn_drop, btn_restart,
    input  panel, play, player, win_a, win_b, draw, busy, err_full
  );

  modport slave (
    input  btn_left, btn_right, btn_drop, btn_restart,
    output panel, play, player, win_a, win_b, draw, busy, err_full
  );
endinterface

// File: rtl/score4_game_ctrl.sv
// Connect-Four engine: cursor, gravity drop, sequential four-direction win scan, run marking.
module score4_game_ctrl #(
  parameter int unsigned ROWS    = 6,
  parameter int unsigned COLS    = 7,
  parameter int unsigned WIN_LEN = 4
) (
  input logic               clk,
  input logic               rst,
  score4_game_ctrl_if.slave bus
);
  localparam int unsigned RowW  = $clog2(ROWS);
  localparam int unsigned ColW  = $clog2(COLS);
  localparam int unsigned RunW  = $clog2(WIN_LEN);
  localparam int unsigned MoveW = $clog2(ROWS * COLS + 1);
  localparam int          RowsI = int'(ROWS);
  localparam int          ColsI = int'(COLS);
  localparam int          WinI  = int'(WIN_LEN);
  localparam logic [MoveW-1:0] MaxMoves = MoveW'(ROWS * COLS);

  typedef logic [ROWS-1:0][COLS-1:0][1:0] panel_t;
  typedef enum logic [3:0] {
    StWait, StScan, StChkH, StChkV, StChkD1, StChkD2, StMark, StWin, StDraw
  } state_e;
  typedef enum logic [1:0] {DirH, DirV, DirD1, DirD2} dir_e;

  // Positive-sense step of each direction; the negative sense is its mirror.
  function automatic int dir_dr(input dir_e d);
    case (d)
      DirH:    return 0;
      DirV:    return 1;
      DirD1:   return 1;
      default: return -1;
    endcase
  endfunction

  function automatic int dir_dc(input dir_e d);
    return (d == DirV) ? 0 : 1;
  endfunction

  function automatic logic in_board(input int r, input int c);
    return (r >= 0) && (r < RowsI) && (c >= 0) && (c < ColsI);
  endfunction

  function automatic logic [RunW-1:0] count_run(input panel_t p, input int r0, input int c0,
                                                 input int dr, input int dc,
                                                 input logic [1:0] code);
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int i = 1; i < WinI; i++) begin
      if (run && in_board(r0 + dr * i, c0 + dc * i) &&
          p[RowW'(r0 + dr * i)][ColW'(c0 + dc * i)] == code) begin
        n++;
      end else begin
        run = 1'b0;
      end
    end
    return RunW'(n);
  endfunction

  state_e             state_q, state_d;
  panel_t             panel_q, panel_d;
  logic [COLS-1:0]    play_q, play_d;
  logic               player_q, player_d;
  logic               win_a_q, win_a_d;
  logic               win_b_q, win_b_d;
  logic               draw_q, draw_d;
  logic               err_full_q, err_full_d;
  logic [MoveW-1:0]   cnt_q, cnt_d;
  logic [RowW-1:0]    row_q, row_d;
  logic [ColW-1:0]    col_q, col_d;
  dir_e               dir_q, dir_d;
  logic [RunW-1:0]    lcnt_q, lcnt_d;
  logic [RunW-1:0]    rcnt_q, rcnt_d;

  logic [ColW-1:0]    cur_col;
  logic [1:0]         code;
  dir_e               chk_dir;
  int                 chk_dr, chk_dc, mark_dr, mark_dc;
  logic [RunW-1:0]    lcnt_c, rcnt_c;
  logic               hit;

  always_comb begin
    cur_col = '0;
    for (int j = 0; j < ColsI; j++) begin
      if (play_q[j]) cur_col = ColW'(j);
    end
  end

  assign code = player_q ? 2'b10 : 2'b01;

  always_comb begin
    case (state_q)
      StChkV:  chk_dir = DirV;
      StChkD1: chk_dir = DirD1;
      StChkD2: chk_dir = DirD2;
      default: chk_dir = DirH;
    endcase
    chk_dr  = dir_dr(chk_dir);
    chk_dc  = dir_dc(chk_dir);
    mark_dr = dir_dr(dir_q);
    mark_dc = dir_dc(dir_q);
    rcnt_c  = count_run(panel_q, int'(row_q), int'(col_q), chk_dr, chk_dc, code);
    // Nothing sits above a freshly dropped piece, so vertical only counts downward.
    lcnt_c  = (chk_dir == DirV) ? '0 :
              count_run(panel_q, int'(row_q), int'(col_q), -chk_dr, -chk_dc, code);
    hit     = (1 + int'(lcnt_c) + int'(rcnt_c)) >= WinI;
  end

  always_comb begin
    state_d    = state_q;
    panel_d    = panel_q;
    play_d     = play_q;
    player_d   = player_q;
    win_a_d    = win_a_q;
    win_b_d    = win_b_q;
    draw_d     = draw_q;
    err_full_d = 1'b0;
    cnt_d      = cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    dir_d      = dir_q;
    lcnt_d     = lcnt_q;
    rcnt_d     = rcnt_q;

    if (bus.btn_restart) begin
      state_d  = StWait;
      panel_d  = '0;
      play_d   = COLS'(1);
      player_d = 1'b0;
      win_a_d  = 1'b0;
      win_b_d  = 1'b0;
      draw_d   = 1'b0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        StWait: begin
          if (bus.btn_drop) begin
            if (panel_q[0][cur_col] != 2'b00) begin
              err_full_d = 1'b1;
            end else begin
              state_d = StScan;
              row_d   = RowW'(ROWS - 1);
              col_d   = cur_col;
            end
          end else if (bus.btn_left && !bus.btn_right) begin
            play_d = {play_q[0], play_q[COLS-1:1]};
          end else if (bus.btn_right && !bus.btn_left) begin
            play_d = {play_q[COLS-2:0], play_q[COLS-1]};
          end
        end
        StScan: begin
          if (panel_q[row_q][col_q] == 2'b00) begin
            panel_d[row_q][col_q] = code;
            state_d               = StChkH;
          end else begin
            row_d = row_q - 1'b1;
          end
        end
        StChkH, StChkV, StChkD1, StChkD2: begin
          if (hit) begin
            dir_d   = chk_dir;
            lcnt_d  = lcnt_c;
            rcnt_d  = rcnt_c;
            state_d = StMark;
          end else begin
            case (state_q)
              StChkH:  state_d = StChkV;
              StChkV:  state_d = StChkD1;
              StChkD1: state_d = StChkD2;
              default: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == MaxMoves) begin
                  draw_d  = 1'b1;
                  state_d = StDraw;
                end else begin
                  player_d = ~player_q;
                  state_d  = StWait;
                end
              end
            endcase
          end
        end
        StMark: begin
          for (int i = -(WinI - 1); i <= WinI - 1; i++) begin
            if (i >= -int'(lcnt_q) && i <= int'(rcnt_q) &&
                in_board(int'(row_q) + mark_dr * i, int'(col_q) + mark_dc * i)) begin
              panel_d[RowW'(int'(row_q) + mark_dr * i)][ColW'(int'(col_q) + mark_dc * i)] = 2'b11;
            end
          end
          win_a_d = ~player_q;
          win_b_d = player_q;
          state_d = StWin;
        end
        StWin, StDraw: ;
        default: state_d = StWait;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StWait;
      panel_q    <= '0;
      play_q     <= COLS'(1);
      player_q   <= 1'b0;
      win_a_q    <= 1'b0;
      win_b_q    <= 1'b0;
      draw_q     <= 1'b0;
      err_full_q <= 1'b0;
      cnt_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      dir_q      <= DirH;
      lcnt_q     <= '0;
      rcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      panel_q    <= panel_d;
      play_q     <= play_d;
      player_q   <= player_d;
      win_a_q    <= win_a_d;
      win_b_q    <= win_b_d;
      draw_q     <= draw_d;
      err_full_q <= err_full_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      dir_q      <= dir_d;
      lcnt_q     <= lcnt_d;
      rcnt_q     <= rcnt_d;
    end
  end

  assign bus.panel    = panel_q;
  assign bus.play     = play_q;
  assign bus.player   = player_q;
  assign bus.win_a    = win_a_q;
  assign bus.win_b    = win_b_q;
  assign bus.draw     = draw_q;
  assign bus.err_full = err_full_q;
  assign bus.busy     = !(state_q inside {StWait, StWin, StDraw});
endmodule

// File: tb/tb_score4_game_ctrl.sv
// Directed bench for score4_game_ctrl: a board model fills a scoreboard that DUT outputs drain.
module tb_score4_game_ctrl;
  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int WIN_LEN = 4;

  typedef logic [ROWS-1:0][COLS-1:0][1:0] panel_t;
  typedef struct {
    string        tag;
    logic [127:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  score4_game_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  score4_game_ctrl #(.ROWS(ROWS), .COLS(COLS), .WIN_LEN(WIN_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t   sb[$];
  int     checks = 0;
  int     errors = 0;
  panel_t m_panel;
  int     m_cur;
  logic   m_player;

  task automatic expect_val(input string tag, input logic [127:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [127:0] obs);
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed %0h required an expectation", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask

  // Called at a negedge; the buttons span exactly one rising edge.
  task automatic press(input logic l, input logic r, input logic d, input logic x);
    bus.btn_left    = l;
    bus.btn_right   = r;
    bus.btn_drop    = d;
    bus.btn_restart = x;
    @(negedge clk);
    bus.btn_left    = 1'b0;
    bus.btn_right   = 1'b0;
    bus.btn_drop    = 1'b0;
    bus.btn_restart = 1'b0;
  endtask

  task automatic wait_busy_low();
    for (int i = 0; i < 40 && bus.busy === 1'b1; i++) @(negedge clk);
  endtask

  task automatic model_drop(input int c);
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (m_panel[3'(r)][3'(c)] == 2'b00) begin
        m_panel[3'(r)][3'(c)] = m_player ? 2'b10 : 2'b01;
        break;
      end
    end
  endtask

  task automatic move_to(input int c);
    while (m_cur != c) begin
      press(1'b0, 1'b1, 1'b0, 1'b0);
      m_cur = (m_cur + 1) % COLS;
    end
  endtask

  task automatic play_move(input int c, input logic toggle);
    move_to(c);
    model_drop(c);
    if (toggle) m_player = ~m_player;
    expect_val("move_idle", 0);
    expect_val("move_panel", m_panel);
    expect_val("move_player", m_player);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    wait_busy_low();
    chk(bus.busy);
    chk(bus.panel);
    chk(bus.player);
  endtask

  task automatic do_restart();
    m_panel  = '0;
    m_cur    = 0;
    m_player = 1'b0;
    expect_val("restart_panel", 0);
    expect_val("restart_play", 1);
    expect_val("restart_player", 0);
    expect_val("restart_wins", 0);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    chk(bus.panel);
    chk(bus.play);
    chk(bus.player);
    chk({bus.win_a, bus.win_b, bus.draw});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed no finish required finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int vert_seq[$];
    int diag_seq[$];
    int draw_seq[$];
    int px[3];
    int py[3];

    bus.btn_left    = 1'b0;
    bus.btn_right   = 1'b0;
    bus.btn_drop    = 1'b0;
    bus.btn_restart = 1'b0;
    m_panel  = '0;
    m_cur    = 0;
    m_player = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    expect_val("rst_panel", 0);
    expect_val("rst_play", 1);
    expect_val("rst_player", 0);
    expect_val("rst_busy", 0);
    expect_val("rst_flags", 0);
    chk(bus.panel);
    chk(bus.play);
    chk(bus.player);
    chk(bus.busy);
    chk({bus.win_a, bus.win_b, bus.draw, bus.err_full});

    // Drop latency into an empty column 0
    model_drop(0);
    expect_val("drop_busy_n", 1);
    expect_val("drop_panel_n1", m_panel);
    expect_val("drop_busy_n4", 1);
    expect_val("drop_busy_n5", 0);
    expect_val("drop_player_n5", 1);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    chk(bus.busy);
    @(negedge clk);
    chk(bus.panel);
    repeat (3) @(negedge clk);
    chk(bus.busy);
    @(negedge clk);
    chk(bus.busy);
    chk(bus.player);
    m_player = 1'b1;

    // Cursor wrap, left+right cancel, drop beats left
    expect_val("left_wrap", 7'b1000000);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    chk(bus.play);
    m_cur = 6;
    expect_val("left_right_hold", 7'b1000000);
    press(1'b1, 1'b1, 1'b0, 1'b0);
    chk(bus.play);
    model_drop(6);
    m_player = 1'b0;
    expect_val("drop_prio_panel", m_panel);
    expect_val("drop_prio_play", 7'b1000000);
    expect_val("drop_prio_player", 0);
    press(1'b1, 1'b0, 1'b1, 1'b0);
    wait_busy_low();
    chk(bus.panel);
    chk(bus.play);
    chk(bus.player);

    // Full column rejects a drop
    for (int i = 0; i < ROWS; i++) play_move(3, 1'b1);
    expect_val("full_err", 1);
    expect_val("full_busy", 0);
    expect_val("full_err_clr", 0);
    expect_val("full_panel", m_panel);
    expect_val("full_player", m_player);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    chk(bus.err_full);
    chk(bus.busy);
    @(negedge clk);
    chk(bus.err_full);
    chk(bus.panel);
    chk(bus.player);
    do_restart();

    // Vertical win for A in column 0
    vert_seq = '{0, 1, 0, 1, 0, 1};
    foreach (vert_seq[i]) play_move(vert_seq[i], 1'b1);
    move_to(0);
    model_drop(0);
    for (int r = 2; r < ROWS; r++) m_panel[3'(r)][0] = 2'b11;
    expect_val("vwin_panel", m_panel);
    expect_val("vwin_flags", 2'b10);
    expect_val("vwin_player", 0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    wait_busy_low();
    chk(bus.panel);
    chk({bus.win_a, bus.win_b});
    chk(bus.player);
    expect_val("vwin_frozen_panel", m_panel);
    expect_val("vwin_frozen_play", 1);
    expect_val("vwin_frozen_busy", 0);
    expect_val("vwin_frozen_flags", 2'b10);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    chk(bus.panel);
    chk(bus.play);
    chk(bus.busy);
    chk({bus.win_a, bus.win_b});
    do_restart();

    // Up-right diagonal win for B, completed at its middle cell (row 3, col 2)
    diag_seq = '{1, 0, 2, 1, 3, 6, 3, 6, 3, 3, 2};
    foreach (diag_seq[i]) play_move(diag_seq[i], 1'b1);
    move_to(2);
    model_drop(2);
    m_panel[5][0] = 2'b11;
    m_panel[4][1] = 2'b11;
    m_panel[3][2] = 2'b11;
    m_panel[2][3] = 2'b11;
    expect_val("dwin_panel", m_panel);
    expect_val("dwin_flags", 2'b01);
    expect_val("dwin_player", 1);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    wait_busy_low();
    chk(bus.panel);
    chk({bus.win_a, bus.win_b});
    chk(bus.player);
    do_restart();

    // 42-move fill with no four-in-a-row anywhere
    px = '{0, 1, 4};
    py = '{2, 3, 6};
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 3; k++) begin
        draw_seq.push_back(px[p]);
        draw_seq.push_back(py[p]);
        draw_seq.push_back(py[p]);
        draw_seq.push_back(px[p]);
      end
    end
    for (int k = 0; k < ROWS; k++) draw_seq.push_back(5);
    foreach (draw_seq[i]) play_move(draw_seq[i], (i != ROWS * COLS - 1));
    expect_val("draw_flags", 3'b001);
    expect_val("draw_player", 1);
    chk({bus.win_a, bus.win_b, bus.draw});
    chk(bus.player);

    // Asynchronous reset clears the board between clock edges
    @(negedge clk);
    #2 rst = 1'b0;
    expect_val("async_rst_panel", 0);
    expect_val("async_rst_draw", 0);
    #1;
    chk(bus.panel);
    chk(bus.draw);
    @(negedge clk);
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
